// File: rtl/credit_link_tx.sv
// credit_link_tx: drains flits from a show-ahead FIFO and frames them into
// packets for an inter-router link that uses credit-based flow control.
//
// The first flit of each packet is a header. Its low LEN_W bits give the number
// of payload flits that follow. No more flits leave than the downstream buffer
// has credits for. A new packet starts only when link_en is high; a packet that
// has already started always runs to its end.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   fifo_data         head-of-FIFO flit (valid when fifo_empty=0)
//   fifo_empty        FIFO empty flag
//   fifo_consume      pop strobe to the FIFO (combinational)
//   link_en           permits starting new packets
//   credit_return     one-cycle pulse: downstream freed one slot
//   out_valid/data/sop/eop  registered link flit and framing flags
//   credits           current credit count
//   credit_err        sticky: credit returned while already full
//   in_packet         high while between header and last payload
//   pkt_count         completed packets (wraps)
module credit_link_tx #(
   parameter int DATA_W  = 64,
   parameter int CREDITS = 8,
   parameter int LEN_W   = 8,
   parameter int CNT_W   = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_W-1:0]              fifo_data,
   input  logic                           fifo_empty,
   output logic                           fifo_consume,
   input  logic                           link_en,
   input  logic                           credit_return,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_sop,
   output logic                           out_eop,
   output logic [$clog2(CREDITS+1)-1:0]   credits,
   output logic                           credit_err,
   output logic                           in_packet,
   output logic [CNT_W-1:0]               pkt_count
);

   localparam int CRW = $clog2(CREDITS+1);

   typedef enum logic [0:0] {IDLE = 1'b0, BODY = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               valid_q, valid_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic [CRW-1:0]     cred_q, cred_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fire_s;
   logic [LEN_W-1:0]   hdr_len_s;

   // Pop when data and a credit are available. Once a packet is underway,
   // link_en is ignored so the packet always completes.
   assign fire_s = ~rst & ~fifo_empty & (cred_q != {CRW{1'b0}})
                 & ((state_q == BODY) | link_en);
   assign fifo_consume = fire_s;
   assign hdr_len_s    = fifo_data[LEN_W-1:0];

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_sop    = sop_q;
   assign out_eop    = eop_q;
   assign credits    = cred_q;
   assign credit_err = err_q;
   assign in_packet  = (state_q == BODY);
   assign pkt_count  = cnt_q;

   // Framing FSM next-state and registered link outputs.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      valid_d = 1'b0;
      data_d  = data_q;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      cnt_d   = cnt_q;
      if (fire_s) begin
         valid_d = 1'b1;
         data_d  = fifo_data;
         case (state_q)
            IDLE: begin
               sop_d = 1'b1;
               if (hdr_len_s == {LEN_W{1'b0}}) begin
                  // Header-only packet: it starts and ends on the same flit.
                  eop_d = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  rem_d   = hdr_len_s;
                  state_d = BODY;
               end
            end
            BODY: begin
               if (rem_q == LEN_W'(1)) begin
                  eop_d   = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
                  rem_d   = {LEN_W{1'b0}};
                  state_d = IDLE;
               end else begin
                  rem_d = rem_q - LEN_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               rem_d   = {LEN_W{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Credit counter: a pop and a return in the same cycle cancel out. A return
   // while already full is a protocol error from downstream and is latched.
   always_comb begin
      cred_d = cred_q;
      err_d  = err_q;
      if (fire_s && !credit_return) begin
         cred_d = cred_q - CRW'(1);
      end else if (credit_return && !fire_s) begin
         if (cred_q == CRW'(CREDITS)) begin
            err_d = 1'b1;
         end else begin
            cred_d = cred_q + CRW'(1);
         end
      end else begin
         cred_d = cred_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= {LEN_W{1'b0}};
         valid_q <= 1'b0;
         data_q  <= {DATA_W{1'b0}};
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         cred_q  <= CRW'(CREDITS);
         err_q   <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         cred_q  <= cred_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_credit_link_tx.sv
module tb_credit_link_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_consume;
   logic        link_en;
   logic        credit_return;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_sop;
   logic        out_eop;
   logic [3:0]  credits;
   logic        credit_err;
   logic        in_packet;
   logic [31:0] pkt_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] fq[$];   // FIFO contents model
   logic [65:0] eq[$];   // expected {data, sop, eop} scoreboard

   credit_link_tx #(.DATA_W(64), .CREDITS(8), .LEN_W(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .fifo_consume(fifo_consume), .link_en(link_en), .credit_return(credit_return),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .credits(credits), .credit_err(credit_err), .in_packet(in_packet),
      .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic upd_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? 64'h0 : fq[0];
   endtask

   task automatic load(input logic [63:0] d, input logic sop, input logic eop);
      fq.push_back(d);
      eq.push_back({d, sop, eop});
      upd_fifo();
   endtask

   task automatic tick();
      logic c;
      #1;
      c = fifo_consume;
      @(posedge clk);
      #1;
      if (c) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_when_empty at %0t", $time);
         end else begin
            void'(fq.pop_front());
         end
      end
      upd_fifo();
   endtask

   task automatic chk_consume(input string name, input logic exp);
      #1;
      chk(name, {71'h0, fifo_consume}, {71'h0, exp});
   endtask

   task automatic return_credits(input int n);
      for (int k = 0; k < n; k++) begin
         credit_return = 1'b1;
         tick();
         credit_return = 1'b0;
      end
   endtask

   // Monitor: every flit on the link is compared against the scoreboard.
   always @(negedge clk) begin
      logic [65:0] e;
      if (out_valid === 1'b1) begin
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit: got %0h with nothing expected", out_data);
         end else begin
            e = eq.pop_front();
            chk("flit", {6'h0, out_data, out_sop, out_eop}, {6'h0, e});
         end
      end else begin
         chk("idle_flags", {70'h0, out_sop, out_eop}, 72'h0);
      end
   end

   initial begin
      rst = 1'b1; link_en = 1'b0; credit_return = 1'b0;
      upd_fifo();
      tick(); tick();
      chk("rst_credits", 72'(credits), 72'd8);
      chk("rst_valid", 72'(out_valid), 72'd0);
      chk("rst_data", 72'(out_data), 72'd0);
      chk("rst_pkt", 72'(pkt_count), 72'd0);
      chk("rst_inpkt", 72'(in_packet), 72'd0);
      chk("rst_err", 72'(credit_err), 72'd0);
      rst = 1'b0;

      // len=3 packet, preloaded
      load(64'hA5A5_0000_0000_0003, 1'b1, 1'b0);
      load(64'h1111_1111_1111_1100, 1'b0, 1'b0);
      load(64'h2222_2222_2222_2200, 1'b0, 1'b0);
      load(64'h3333_3333_3333_3300, 1'b0, 1'b1);
      chk_consume("hold_no_link", 1'b0);
      link_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_valid", 72'(out_valid), 72'd1);
      end
      tick();
      chk("t1_valid_end", 72'(out_valid), 72'd0);
      chk("t1_credits", 72'(credits), 72'd4);
      chk("t1_pkt", 72'(pkt_count), 72'd1);
      chk("t1_inpkt", 72'(in_packet), 72'd0);
      return_credits(4);
      chk("t1_restored", 72'(credits), 72'd8);

      // header-only packet
      load(64'hB0B0_0000_0000_0000, 1'b1, 1'b1);
      tick();
      chk("len0_valid", 72'(out_valid), 72'd1);
      chk("len0_inpkt", 72'(in_packet), 72'd0);
      chk("len0_pkt", 72'(pkt_count), 72'd2);
      return_credits(1);

      // link_en dropped after header
      load(64'hC0C0_0000_0000_0002, 1'b1, 1'b0);
      load(64'hC1C1_0000_0000_0000, 1'b0, 1'b0);
      load(64'hC2C2_0000_0000_0000, 1'b0, 1'b1);
      load(64'hD0D0_0000_0000_0000, 1'b1, 1'b1);
      tick();
      link_en = 1'b0;
      tick(); tick(); tick(); tick();
      chk("drop_valid", 72'(out_valid), 72'd0);
      chk("drop_inpkt", 72'(in_packet), 72'd0);
      chk("drop_pkt", 72'(pkt_count), 72'd3);
      chk("drop_credits", 72'(credits), 72'd5);
      chk_consume("drop_hold", 1'b0);
      link_en = 1'b1;
      tick();
      chk("drop_resume_valid", 72'(out_valid), 72'd1);
      chk("drop_resume_pkt", 72'(pkt_count), 72'd4);
      return_credits(4);

      // credit exhaustion: 10-flit packet against 8 credits
      link_en = 1'b0;
      load(64'hE0E0_0000_0000_0009, 1'b1, 1'b0);
      for (int i = 1; i <= 9; i++) load(64'hE1E1_0000_0000_0000 + 64'(i << 8), 1'b0, i == 9);
      link_en = 1'b1;
      repeat (8) tick();
      chk("ex_credits0", 72'(credits), 72'd0);
      chk_consume("ex_no_pop", 1'b0);
      tick(); tick();
      chk("ex_stall_valid", 72'(out_valid), 72'd0);
      chk("ex_stall_inpkt", 72'(in_packet), 72'd1);
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      chk("ex_credit1", 72'(credits), 72'd1);
      chk_consume("ex_pop1", 1'b1);
      tick();
      chk("ex_one_valid", 72'(out_valid), 72'd1);
      chk("ex_credit_again0", 72'(credits), 72'd0);
      chk_consume("ex_no_pop2", 1'b0);
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      tick();
      chk("ex_last_valid", 72'(out_valid), 72'd1);
      chk("ex_pkt", 72'(pkt_count), 72'd5);
      chk("ex_inpkt", 72'(in_packet), 72'd0);

      // simultaneous pop and credit return
      return_credits(4);
      link_en = 1'b0;
      load(64'hF0F0_0000_0000_0009, 1'b1, 1'b0);
      for (int i = 1; i <= 9; i++) load(64'hF1F1_0000_0000_0000 + 64'(i << 8), 1'b0, i == 9);
      link_en = 1'b1;
      credit_return = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("sim_credits", 72'(credits), 72'd4);
      end
      credit_return = 1'b0;
      tick();
      chk("sim_valid_end", 72'(out_valid), 72'd0);
      chk("sim_pkt", 72'(pkt_count), 72'd6);
      return_credits(4);

      // credit return while full
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      chk("err_credits", 72'(credits), 72'd8);
      chk("err_set", 72'(credit_err), 72'd1);
      tick(); tick();
      chk("err_sticky", 72'(credit_err), 72'd1);

      // reset mid-packet
      link_en = 1'b0;
      load(64'h7070_0000_0000_0003, 1'b1, 1'b0);
      load(64'h7171_0000_0000_0000, 1'b0, 1'b0);
      link_en = 1'b1;
      tick(); tick(); tick(); tick();
      chk("mid_inpkt", 72'(in_packet), 72'd1);
      chk("mid_empty_valid", 72'(out_valid), 72'd0);
      chk("mid_credits", 72'(credits), 72'd6);
      rst = 1'b1;
      load(64'h8080_0000_0000_0000, 1'b1, 1'b1);
      chk_consume("rst_no_pop", 1'b0);
      tick();
      chk("rst2_credits", 72'(credits), 72'd8);
      chk("rst2_err", 72'(credit_err), 72'd0);
      chk("rst2_inpkt", 72'(in_packet), 72'd0);
      chk("rst2_pkt", 72'(pkt_count), 72'd0);
      chk("rst2_valid", 72'(out_valid), 72'd0);
      chk("rst2_data", 72'(out_data), 72'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_valid", 72'(out_valid), 72'd1);
      chk("post_rst_pkt", 72'(pkt_count), 72'd1);
      tick(); tick();
      chk("scoreboard_drained", 72'(eq.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/credit_link_tx.md
Name: credit_link_tx

Overview:
- Drain stage directly downstream of the router's input/output FIFO.
- Pops flits from a show-ahead FIFO (data valid whenever not empty; a consume pulse advances the head).
- Frames them into packets using a header length field and transmits them on an inter-router link with credit-based flow control.
- Never sends more flits than the downstream buffer has credits for, and gates new packets on a link enable.

Parameters:
- DATA_W, 64, flit width; matches the FIFO data width.
- CREDITS, 8, downstream buffer slots; this is the reset value of the credit counter.
- LEN_W, 8, width of the payload-length field in header bits [LEN_W-1:0].
- CNT_W, 32, width of the packet statistics counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- fifo_data  in  DATA_W  head-of-FIFO flit; valid when fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_consume  out  1  pop strobe to the FIFO; combinational.
- link_en  in  1  permits starting new packets.
- credit_return  in  1  one-cycle pulse; the downstream freed one slot.
- out_valid  out  1  registered; one flit on the link this cycle.
- out_data  out  DATA_W  registered flit.
- out_sop  out  1  registered; this flit is a header.
- out_eop  out  1  registered; this flit is the last of its packet.
- credits  out  $clog2(CREDITS+1)  current credit count.
- credit_err  out  1  sticky; a credit was returned while already at CREDITS.
- in_packet  out  1  FSM is in BODY.
- pkt_count  out  CNT_W  packets completed; wraps.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - credits=CREDITS.
  - out_valid, out_sop, out_eop, credit_err, in_packet = 0.
  - out_data=0, pkt_count=0.
  - FSM=IDLE, remaining=0.
- Reset mid-packet: abandons the packet with no eop emitted. Credits are restored to CREDITS.
- Pop condition: fire = ~fifo_empty & (credits!=0) & (state==BODY | link_en).
  - fifo_consume=fire. It is never asserted while fifo_empty=1, while credits==0, or during rst.
- Latency: on the edge after fire, out_data<=fifo_data and out_valid<=1. Otherwise out_valid<=0.
  - out_data holds its last value when out_valid=0.
  - One flit per cycle maximum; back-to-back pops give a continuous out_valid.
- FSM IDLE, on fire (header flit):
  - out_sop<=1.
  - len=fifo_data[LEN_W-1:0].
  - If len==0: out_eop<=1, pkt_count++, stay in IDLE.
  - Else: remaining<=len, go to BODY.
- FSM BODY, on fire (payload flit):
  - out_sop<=0.
  - If remaining==1: out_eop<=1, pkt_count++, go to IDLE.
  - Else: remaining--, out_eop<=0.
- out_sop and out_eop are 0 whenever out_valid is 0.
- link_en:
  - Sampled only in IDLE.
  - Deasserting it mid-packet does not stall the packet; the packet completes, then the block halts at the boundary.
- Credit counter:
  - fire & ~credit_return: credits-1.
  - credit_return & ~fire: credits+1, unless credits==CREDITS. In that case the count is unchanged and credit_err<=1.
  - fire & credit_return in the same cycle: unchanged.
  - credits never underflows, because fire requires credits!=0.
- credit_err clears only on rst.
- FIFO empty mid-packet: the block stays in BODY with no output and resumes on the next non-empty cycle. There is no timeout.
- Maximum packet length is 1 + (2^LEN_W - 1) flits.
- in_packet=(state==BODY).

Test Plan:
- Header len=3 followed by 3 payloads preloaded, credits=8, link_en=1 -> 4 consecutive out_valid cycles starting 1 cycle after the first pop. sop on flit 0, eop on flit 3; credits 8->4; pkt_count=1.
- CREDITS=2, 5-flit packet, no credit_return -> exactly 2 flits sent, then fifo_consume=0 and credits=0. Pulse credit_return once -> exactly 1 more flit.
- Simultaneous fire and credit_return over 10 cycles -> credits constant; all flits are still sent.
- Header len=0 -> single flit with out_sop=out_eop=1; FSM stays IDLE; pkt_count increments.
- link_en dropped after the header of a len=2 packet -> both payloads still sent. The next header stays in the FIFO (fifo_consume=0) until link_en=1.
- credit_return at credits=CREDITS -> credits unchanged and credit_err=1 stays high. rst mid-packet -> all outputs return to reset values and credits=CREDITS.
